// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
// Module   : register_file_param
// Brief    : 2R/1W register file with R0 hardwired to zero, optional bypass,
//            read-hold enable, sequential clear sweep and sticky R0-write flag.
// Revision : 1.0
// ============================================================================
module register_file_param #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 3,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Rw,
    input  logic              enWrite,
    input  logic              enRead,
    input  logic [DATA_W-1:0] BusW,
    input  logic              clear,
    input  logic              r0_err_clr,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic              busy,
    output logic              r0_err
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              wr_en;
    logic              r0_wr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign idle  = (state == IDLE);
    assign wr_en = idle && enWrite && (Rw != '0);
    assign r0_wr = idle && enWrite && (Rw == '0);
    assign busy  = (state == CLEAR);

    // Per-port forwarding: each read port sees BusW only on its own address match.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (Ra != '0) begin
            rd_a = (BYPASS && wr_en && (Ra == Rw)) ? BusW : mem[Ra];
        end
        if (Rb != '0) begin
            rd_b = (BYPASS && wr_en && (Rb == Rw)) ? BusW : mem[Rb];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear) next_state = CLEAR;
            CLEAR:   if (ptr == PTR_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= PTR_FIRST;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                ptr <= (ptr == PTR_LAST) ? PTR_FIRST : ptr + PTR_FIRST;
            end else begin
                ptr <= PTR_FIRST;
            end
        end
    end

    // Entry 0 is never written: writes require Rw != 0 and the sweep starts at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[Rw] <= BusW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BusA <= '0;
            BusB <= '0;
        end else if (idle && enRead) begin
            BusA <= rd_a;
            BusB <= rd_b;
        end
    end

    // Set has priority over clear so a simultaneous attempt is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_err <= 1'b0;
        end else if (r0_wr) begin
            r0_err <= 1'b1;
        end else if (r0_err_clr) begin
            r0_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
